// File: rtl/cross_product_arbiter.sv
// cross_product_arbiter: round-robin shared two-stage (p1-ref)x(p2-ref) unit with tagged broadcast response
module cross_product_arbiter #(
  parameter int N_REQ   = 4,
  parameter int COORD_W = 10,
  parameter int ID_W    = 2,
  parameter int RES_W   = 2*COORD_W+2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*6*COORD_W-1:0] req_data,
  output logic [N_REQ-1:0]           grant,
  output logic                       busy,
  output logic                       rsp_valid,
  output logic [ID_W-1:0]            rsp_id,
  output logic [RES_W-1:0]           rsp_result,
  output logic                       rsp_pos
);
  localparam int D = COORD_W+1;
  localparam int P = 2*COORD_W+2;
  localparam int W = 6*COORD_W;
  function automatic logic [ID_W-1:0] wrap(input int v);
    return ID_W'(v % N_REQ);
  endfunction
  logic [ID_W-1:0] rr_ptr, gnt_id;
  logic [W-1:0] slot [N_REQ];
  logic [W-1:0] sel;
  logic s1_valid;
  logic [ID_W-1:0] s1_id;
  logic signed [D-1:0] s1_dx1, s1_dy1, s1_dx2, s1_dy2;
  logic signed [D-1:0] dx1, dy1, dx2, dy2;
  logic signed [P-1:0] pa, pb;
  logic signed [RES_W-1:0] res;
  for (genvar i = 0; i < N_REQ; i++) begin : g_slot
    assign slot[i] = req_data[i*W +: W];
  end
  // Walk offsets from the far end so the nearest requester at or after rr_ptr wins
  always_comb begin
    grant = '0;
    gnt_id = '0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      if (en && !reset && req[wrap(int'(rr_ptr) + k)]) begin
        grant = '0;
        grant[wrap(int'(rr_ptr) + k)] = 1'b1;
        gnt_id = wrap(int'(rr_ptr) + k);
      end
    end
  end
  assign sel = slot[gnt_id];
  assign dx1 = $signed({1'b0, sel[4*COORD_W-1 -: COORD_W]}) - $signed({1'b0, sel[6*COORD_W-1 -: COORD_W]});
  assign dy1 = $signed({1'b0, sel[3*COORD_W-1 -: COORD_W]}) - $signed({1'b0, sel[5*COORD_W-1 -: COORD_W]});
  assign dx2 = $signed({1'b0, sel[2*COORD_W-1 -: COORD_W]}) - $signed({1'b0, sel[6*COORD_W-1 -: COORD_W]});
  assign dy2 = $signed({1'b0, sel[COORD_W-1:0]})            - $signed({1'b0, sel[5*COORD_W-1 -: COORD_W]});
  assign pa = P'(s1_dx1) * P'(s1_dy2);
  assign pb = P'(s1_dx2) * P'(s1_dy1);
  assign res = pa - pb;
  assign busy = s1_valid | rsp_valid;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
      s1_valid <= 1'b0;
      s1_id <= '0;
      s1_dx1 <= '0;
      s1_dy1 <= '0;
      s1_dx2 <= '0;
      s1_dy2 <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_result <= '0;
      rsp_pos <= 1'b0;
    end else begin
      s1_valid <= |grant;
      rsp_valid <= s1_valid;
      if (|grant) begin
        rr_ptr <= wrap(int'(gnt_id) + 1);
        s1_id <= gnt_id;
        s1_dx1 <= dx1;
        s1_dy1 <= dy1;
        s1_dx2 <= dx2;
        s1_dy2 <= dy2;
      end
      if (s1_valid) begin
        rsp_id <= s1_id;
        rsp_result <= res;
        rsp_pos <= !res[RES_W-1] && |res;
      end
    end
  end
endmodule

// File: tb/tb_cross_product_arbiter.sv
// tb_cross_product_arbiter: scoreboard bench for round-robin grants and tagged cross-product responses
module tb_cross_product_arbiter;
  localparam int N = 4;
  localparam int C = 10;
  localparam int ID = 2;
  localparam int R = 2*C+2;
  localparam int W = 6*C;
  typedef struct packed {
    logic [ID-1:0] id;
    logic signed [R-1:0] res;
  } exp_t;
  logic clk = 1'b0;
  logic reset, en;
  logic [N-1:0] req, grant;
  logic [N*W-1:0] req_data;
  logic busy, rsp_valid, rsp_pos;
  logic [ID-1:0] rsp_id;
  logic [R-1:0] rsp_result;
  exp_t sb[$];
  int total = 0, passed = 0;
  int m_ptr = 0;
  logic m_s1 = 1'b0, m_rv = 1'b0;
  logic [ID-1:0] last_id = '0;
  logic signed [R-1:0] last_res = '0;
  cross_product_arbiter #(.N_REQ(N), .COORD_W(C), .ID_W(ID), .RES_W(R)) dut (
    .clk(clk), .reset(reset), .en(en), .req(req), .req_data(req_data), .grant(grant),
    .busy(busy), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_pos(rsp_pos)
  );
  always #5 clk = ~clk;
  function automatic longint cp(input logic [W-1:0] w);
    longint rx, ry, ax, ay, bx, by;
    rx = longint'(w[59:50]); ry = longint'(w[49:40]);
    ax = longint'(w[39:30]); ay = longint'(w[29:20]);
    bx = longint'(w[19:10]); by = longint'(w[9:0]);
    return (ax-rx)*(by-ry) - (bx-rx)*(ay-ry);
  endfunction
  task automatic set_slot(input int i, input int rx, input int ry, input int ax, input int ay, input int bx, input int by);
    req_data[i*W +: W] = {10'(rx), 10'(ry), 10'(ax), 10'(ay), 10'(bx), 10'(by)};
  endtask
  // One cycle: check outputs at the falling edge against the model, then advance the model across the rising edge
  task automatic step();
    logic [N-1:0] g;
    int gi;
    exp_t e;
    g = '0;
    gi = 0;
    @(negedge clk);
    total++;
    if (rsp_valid !== m_rv) $display("FAIL rsp_valid got %b want %b at %0t", rsp_valid, m_rv, $time);
    else passed++;
    total++;
    if (busy !== (m_s1 | m_rv)) $display("FAIL busy got %b want %b at %0t", busy, m_s1 | m_rv, $time);
    else passed++;
    if (m_rv && sb.size() > 0) begin
      e = sb.pop_front();
      last_id = e.id;
      last_res = e.res;
    end
    total++;
    if (rsp_id !== last_id) $display("FAIL rsp_id got %0d want %0d at %0t", rsp_id, last_id, $time);
    else passed++;
    total++;
    if ($signed(rsp_result) !== last_res) $display("FAIL rsp_result got %0d want %0d at %0t", $signed(rsp_result), last_res, $time);
    else passed++;
    total++;
    if (rsp_pos !== (last_res > 0)) $display("FAIL rsp_pos got %b want %b at %0t", rsp_pos, last_res > 0, $time);
    else passed++;
    if (!reset && en)
      for (int k = N-1; k >= 0; k--) begin
        int j;
        j = (m_ptr + k) % N;
        if (req[j]) begin
          g = '0;
          g[j] = 1'b1;
          gi = j;
        end
      end
    total++;
    if (grant !== g) $display("FAIL grant got %b want %b at %0t", grant, g, $time);
    else passed++;
    m_rv = m_s1;
    m_s1 = |g;
    if (|g) begin
      e.id = ID'(gi);
      e.res = R'(cp(req_data[gi*W +: W]));
      sb.push_back(e);
      m_ptr = (gi + 1) % N;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    sb.delete();
    m_s1 = 1'b0;
    m_rv = 1'b0;
    m_ptr = 0;
    last_id = '0;
    last_res = '0;
    repeat (2) step();
    reset = 1'b0;
  endtask
  task automatic drain();
    req = '0;
    repeat (3) step();
  endtask
  task automatic test_reset();
    req = '1;
    en = 1'b1;
    do_reset();
    req = '0;
    step();
  endtask
  task automatic test_single_op();
    set_slot(0, 0, 0, 3, 0, 0, 4);
    req = 4'b0001;
    step();
    req = '0;
    step();
    total++;
    if (!(rsp_valid === 1'b1 && rsp_id === 2'd0 && $signed(rsp_result) === 22'sd12 && rsp_pos === 1'b1))
      $display("FAIL single_op got v=%b id=%0d res=%0d pos=%b want v=1 id=0 res=12 pos=1", rsp_valid, rsp_id, $signed(rsp_result), rsp_pos);
    else passed++;
    drain();
  endtask
  task automatic test_sign();
    set_slot(2, 0, 0, 1023, 0, 0, 1023);
    req = 4'b0100;
    step();
    set_slot(2, 0, 0, 0, 1023, 1023, 0);
    step();
    set_slot(2, 5, 5, 5, 5, 5, 5);
    step();
    drain();
  endtask
  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++)
      set_slot(i, 10*i, 20, 100+i, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 300-i);
    req = 4'b1111;
    repeat (6) step();
    drain();
  endtask
  task automatic test_fairness();
    req = 4'b0100;
    step();
    req = 4'b1011;
    repeat (3) step();
    drain();
  endtask
  task automatic test_en();
    req = 4'b1111;
    step();
    en = 1'b0;
    repeat (4) step();
    en = 1'b1;
    step();
    drain();
  endtask
  task automatic test_back_to_back();
    set_slot(1, 512, 512, 0, 1023, 1023, 0);
    req = 4'b0010;
    repeat (4) step();
    drain();
  endtask
  task automatic test_reset_mid();
    set_slot(0, 1, 2, 30, 40, 50, 7);
    req = 4'b0001;
    step();
    req = '0;
    do_reset();
    req = 4'b0110;
    step();
    drain();
  endtask
  initial begin
    reset = 1'b0;
    en = 1'b0;
    req = '0;
    req_data = '0;
    #2;
    test_reset();
    test_single_op();
    test_sign();
    test_round_robin();
    test_fairness();
    test_en();
    test_back_to_back();
    test_reset_mid();
    total++;
    if (sb.size() != 0) $display("FAIL scoreboard_empty got %0d pending want 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/cross_product_arbiter.md
Name: cross_product_arbiter

Overview:
- Shares one pipelined cross-product unit among N_REQ requesters, e.g. the vertex-sort and inside-test sequencers of parallel geofence engines.
- Requesters hold a request with operands; the block grants one requester per cycle in round-robin order.
- It computes (p1-ref)x(p2-ref) over two pipeline stages.
- It returns the signed result, tagged with the requester ID, on a broadcast response bus.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- COORD_W, 10, unsigned coordinate width
- ID_W, 2, width of the requester tag; must satisfy 2**ID_W >= N_REQ
- RES_W, 2*COORD_W+2, signed result width

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- en  input  1  arbitration enable; when low no new grants, in-flight ops drain
- req  input  N_REQ  per-requester request, level
- req_data  input  N_REQ*6*COORD_W  per slot i, packed MSB-first {ref_x, ref_y, p1_x, p1_y, p2_x, p2_y}
- grant  output  N_REQ  one-hot; combinational; operands of the granted slot are sampled at this clock edge
- busy  output  1  high while any pipeline stage holds a valid op
- rsp_valid  output  1  registered result strobe, one cycle per op
- rsp_id  output  ID_W  index of the requester that owns the result
- rsp_result  output  RES_W  signed (p1x-rx)*(p2y-ry) - (p2x-rx)*(p1y-ry)
- rsp_pos  output  1  rsp_result > 0 (counter-clockwise turn)

Behaviour:
- Reset (async):
  - rr_ptr=0; stage valids=0.
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_pos=0, busy=0.
  - grant=0 while reset is high.
- Arbitration (combinational):
  - If en=1, grant the first i with req[i]=1, searching from rr_ptr upward with wrap at N_REQ-1 to 0.
  - At most one grant bit is set. grant=0 if en=0 or req=0.
- Pointer update: on any clock edge with a grant to i, rr_ptr <= (i+1) mod N_REQ. Otherwise rr_ptr holds.
- Handshake:
  - A requester holds req and req_data stable until it sees grant high at a clock edge. That edge completes the transfer.
  - The requester may deassert req the following cycle, or keep req high to issue back-to-back ops.
  - Dropping req before a grant is legal and issues nothing.
  - Unsliced req_data is ignored.
- Stage 1 (edge with grant):
  - Register the ID and the four differences dx1, dy1, dx2, dy2 as (COORD_W+1)-bit signed values, zero-extended before subtraction.
  - s1_valid <= |grant.
- Stage 2 (next edge):
  - Compute both products at 2*COORD_W+2 bits signed and subtract in RES_W. No overflow is possible for unsigned COORD_W inputs.
  - Register rsp_result, rsp_pos, rsp_id, and rsp_valid <= s1_valid.
- Latency and throughput:
  - Grant at edge T gives rsp_valid high in the cycle after edge T+1.
  - Sustained throughput is 1 op/cycle. No backpressure: consumers must accept every rsp_valid.
- When rsp_valid=0, rsp_result, rsp_id and rsp_pos hold their last values.
- busy = s1_valid | rsp_valid.
- State machine per pipeline slot: EMPTY/FULL via the valid bit only. The arbiter is stateless apart from rr_ptr.
- Boundary conditions:
  - en falling mid-stream: ops already granted complete. No new grants; rr_ptr frozen.
  - Identical points (p1=ref or p2=ref): result 0, rsp_pos=0.
  - Single requester holding req: granted every cycle.
  - Reset mid-operation: in-flight ops are discarded with no rsp_valid. After reset release, arbitration restarts at slot 0.

Test Plan:
- Single op: slot 0, ref(0,0), p1(3,0), p2(0,4) -> grant=0001 at edge T; rsp_valid after T+1 with rsp_id=0, rsp_result=12, rsp_pos=1.
- Sign and extreme values: slot 2, ref(0,0), p1(1023,0), p2(0,1023) -> +1046529, pos=1. Then p1/p2 swapped -> -1046529, pos=0. Then p1=p2=ref=(5,5) -> 0, pos=0.
- Round-robin: all 4 req held continuously with distinct operands -> grants 0,1,2,3,0,1 on consecutive cycles. rsp_id follows the same sequence two cycles later, each result matching its slot.
- Fairness after partial traffic: grant slot 2, then req=1011 -> next grant slot 3, then 0, then 1. Slot 2 is not granted while its req is low.
- en control: en=0 with req=1111 -> grant=0000 and no rsp_valid. In-flight ops still deliver, busy falls once drained. Raising en resumes at the frozen rr_ptr.
- Reset mid-op: grant at edge T, assert reset before edge T+1 -> no rsp_valid, busy=0, rr_ptr=0. Next grant with req=0110 goes to slot 1.
